// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage with a DEPTH-entry prefetch queue. Owns the fetch
//   PC, issues requests to an instruction memory with a fixed one-cycle read
//   latency, buffers {pc, instr} pairs in a circular queue and hands the head
//   entry to decode through a valid/ready handshake. A branch redirect
//   flushes the queue and the in-flight request; halt stops new requests
//   while the queue keeps draining.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   imem_req_valid  out  fetch request issued this cycle
//   imem_req_addr   out  fetch address (current fetch PC)
//   imem_rsp_data   in   instruction, valid one cycle after a request
//   redirect_valid  in   taken branch/jump: flush and refetch
//   redirect_pc     in   new fetch PC on redirect
//   halt            in   stop issuing new fetches
//   id_ready        in   decode accepts the head entry (0 = stall)
//   id_valid        out  head entry valid
//   id_instr        out  head instruction
//   id_pc           out  PC of the head instruction
//   q_count         out  number of entries currently held
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic [INSTR_W-1:0]       imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [INSTR_W-1:0]       id_instr,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Control state
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    // Datapath state (no reset needed: only read when qualified by control)
    logic [ADDR_W-1:0]  r_req_pc;
    logic [ADDR_W-1:0]  r_pc_q    [DEPTH];
    logic [INSTR_W-1:0] r_instr_q [DEPTH];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [CW:0]        w_used;

    assign w_valid = (r_count != '0);

    // A pop during a redirect cycle is ignored: the queue is being flushed.
    assign w_pop  = w_valid & id_ready & ~redirect_valid;

    // The response of the in-flight request is dropped when a redirect arrives
    // in the same cycle, since it belongs to the abandoned path.
    assign w_push = r_inflight & ~redirect_valid;

    // Credit check: queued + in-flight entries, minus the slot freed by a pop
    // this cycle, must leave room for the new request's response.
    assign w_used  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_issue = ~halt & ~redirect_valid & (w_used < (CW+1)'(DEPTH));

    // Reset gating keeps the request strobe low while reset is held, even
    // though the credit logic would otherwise allow an issue.
    assign imem_req_valid = w_issue & reset;
    assign imem_req_addr  = r_fetch_pc;

    assign id_valid = w_valid;
    assign id_pc    = w_valid ? r_pc_q[r_head]    : '0;
    assign id_instr = w_valid ? r_instr_q[r_head] : '0;
    assign q_count  = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_req_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_pc_q[r_tail]    <= r_req_pc;
            r_instr_q[r_tail] <= imem_rsp_data;
        end
    end

    // The credit rule makes a push into a full queue without a matching pop
    // impossible; flag it if it ever happens.
    property p_no_overflow;
        @(posedge clk) disable iff (!reset)
            !(w_push && !w_pop && (r_count == CW'(DEPTH)));
    endproperty
    a_no_overflow: assert property (p_no_overflow);

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        reset, imem_req_valid, redirect_valid, halt, id_ready, id_valid;
    logic [15:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;
    logic [2:0]  q_count;

    // Wrap instance (RESET_PC = 0xFFFC)
    logic        reset2, imem_req_valid2, redirect_valid2, halt2, id_ready2, id_valid2;
    logic [15:0] imem_req_addr2, imem_rsp_data2, redirect_pc2, id_instr2, id_pc2;
    logic [2:0]  q_count2;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] sb  [$];
    logic [31:0] sb2 [$];

    if_fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .q_count(q_count)
    );

    if_fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(16'hFFFC)) u_dut_wrap (
        .clk(clk), .reset(reset2),
        .imem_req_valid(imem_req_valid2), .imem_req_addr(imem_req_addr2), .imem_rsp_data(imem_rsp_data2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .halt(halt2),
        .id_ready(id_ready2), .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .q_count(q_count2)
    );

    // Memory contents: word i (byte address 2*i) holds 0x1000 + i.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'h1000 + {1'b0, a[15:1]};
    endfunction

    // One-cycle-latency memories: request sampled mid-cycle, data driven just
    // after the next rising edge and held for the following cycle.
    logic        m1_v, m2_v;
    logic [15:0] m1_a, m2_a;
    always @(negedge clk) begin
        m1_v = imem_req_valid;  m1_a = imem_req_addr;
        m2_v = imem_req_valid2; m2_a = imem_req_addr2;
    end
    always @(posedge clk) begin
        #1;
        if (m1_v) imem_rsp_data  = mem_f(m1_a);
        if (m2_v) imem_rsp_data2 = mem_f(m2_a);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sequential stream starting at byte address base.
    task automatic fill_sb(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({base + 16'(2*i), 16'h1000 + {1'b0, base[15:1]} + 16'(i)});
    endtask

    // Monitors: every accepted transfer to decode is checked against the queue.
    always @(negedge clk) begin
        if (reset && id_valid && id_ready && !redirect_valid) begin
            if (sb.size() == 0) check("unexpected_pop", {id_pc, id_instr}, 32'hxxxxxxxx);
            else check("sb_pop", {id_pc, id_instr}, sb.pop_front());
        end
        if (reset2 && id_valid2 && id_ready2 && !redirect_valid2 && sb2.size() != 0)
            check("sb2_pop_wrap", {id_pc2, id_instr2}, sb2.pop_front());
    end

    // Wrap instance stimulus
    initial begin
        reset2 = 1'b0; id_ready2 = 1'b0; halt2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        sb2.push_back(32'hFFFC_8FFE);
        sb2.push_back(32'hFFFE_8FFF);
        sb2.push_back(32'h0000_1000);
        sb2.push_back(32'h0002_1001);
        tick(); tick();
        reset2 = 1'b1; id_ready2 = 1'b1;
        @(negedge clk); check("wrap_first_req", imem_req_addr2, 16'hFFFC);
        tick(); tick();
        @(negedge clk); check("wrap_first_pc", id_pc2, 16'hFFFC);
    end

    // Main stimulus
    initial begin
        reset = 1'b0; id_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_id_valid", id_valid, 0);
        check("rst_q_count", q_count, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_instr", id_instr, 0);

        // Fill and stream
        tick(); reset = 1'b1; id_ready = 1'b1; fill_sb(16'h0000, 40);
        @(negedge clk); check("a0_req_valid", imem_req_valid, 1); check("a0_addr", imem_req_addr, 16'h0000);
        check("a0_id_valid", id_valid, 0);
        tick(); @(negedge clk); check("a1_addr", imem_req_addr, 16'h0002); check("a1_id_valid", id_valid, 0);
        tick(); @(negedge clk); check("a2_id_valid", id_valid, 1); check("a2_id_pc", id_pc, 16'h0000);
        check("a2_id_instr", id_instr, 16'h1000);
        repeat (5) tick();

        // Decode stall fills the queue
        tick(); id_ready = 1'b0;
        @(negedge clk); check("stall_start_pc", id_pc, 16'h000C); check("stall_start_cnt", q_count, 1);
        repeat (9) tick();
        @(negedge clk); check("full_cnt", q_count, 4); check("full_req_valid", imem_req_valid, 0);
        check("full_id_pc", id_pc, 16'h000C); check("full_id_valid", id_valid, 1);
        tick(); id_ready = 1'b1;
        @(negedge clk); check("drain_pc0", id_pc, 16'h000C); check("drain_cnt", q_count, 4);
        check("drain_req_valid", imem_req_valid, 1); check("drain_addr", imem_req_addr, 16'h0014);
        tick(); @(negedge clk); check("drain_pc1", id_pc, 16'h000E); check("drain_cnt1", q_count, 3);
        repeat (3) tick();

        // Redirect with 3 queued and 1 in flight
        redirect_valid = 1'b1; redirect_pc = 16'h0040; sb.delete(); fill_sb(16'h0040, 40);
        @(negedge clk); check("redir_cnt_before", q_count, 3); check("redir_id_valid", id_valid, 1);
        check("redir_id_pc", id_pc, 16'h0014); check("redir_req_valid", imem_req_valid, 0);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); check("redir_flush_cnt", q_count, 0); check("redir_flush_valid", id_valid, 0);
        check("redir_req_valid1", imem_req_valid, 1); check("redir_req_addr", imem_req_addr, 16'h0040);
        tick(); @(negedge clk); check("redir_gap_valid", id_valid, 0);
        tick(); @(negedge clk); check("redir_first_pc", id_pc, 16'h0040); check("redir_first_instr", id_instr, 16'h1020);

        // Halt for 5 cycles
        tick(); halt = 1'b1;
        @(negedge clk); check("halt_req_valid", imem_req_valid, 0); check("halt_pc0", id_pc, 16'h0042);
        tick(); @(negedge clk); check("halt_inflight_pc", id_pc, 16'h0044); check("halt_inflight_vld", id_valid, 1);
        tick(); @(negedge clk); check("halt_empty_vld", id_valid, 0); check("halt_empty_req", imem_req_valid, 0);
        tick(); tick();
        @(negedge clk); check("halt_end_vld", id_valid, 0); check("halt_end_cnt", q_count, 0);
        check("halt_end_req", imem_req_valid, 0);
        tick(); halt = 1'b0;
        @(negedge clk); check("resume_req", imem_req_valid, 1); check("resume_addr", imem_req_addr, 16'h0046);
        tick(); tick();
        @(negedge clk); check("resume_pc", id_pc, 16'h0046);

        // Reset mid-operation with 2 queued and 1 in flight
        tick(); id_ready = 1'b0;
        tick();
        @(negedge clk); check("pre_rst_cnt", q_count, 2); check("pre_rst_pc", id_pc, 16'h0048);
        #2; reset = 1'b0; #1;
        check("mid_rst_valid", id_valid, 0); check("mid_rst_cnt", q_count, 0);
        check("mid_rst_req", imem_req_valid, 0); check("mid_rst_pc", id_pc, 0);
        check("mid_rst_instr", id_instr, 0); check("mid_rst_addr", imem_req_addr, 0);
        sb.delete(); fill_sb(16'h0000, 10);
        tick(); tick();
        reset = 1'b1; id_ready = 1'b1;
        @(negedge clk); check("post_rst_cnt", q_count, 0); check("post_rst_addr", imem_req_addr, 16'h0000);
        tick(); tick();
        @(negedge clk); check("post_rst_pc", id_pc, 16'h0000); check("post_rst_instr", id_instr, 16'h1000);
        repeat (3) tick();

        check("wrap_all_delivered", sb2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
